// File: rtl/alu_multdiv.sv
// alu_multdiv: execute-stage ALU with an iterative multiply/divide engine.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   op_valid  qualifies fncode/a/b/shamt this cycle
//   fncode    MIPS R-type funct; 6'b111111 is a no-op
//   a, b      operands (rs, rt/immediate)
//   shamt     shift amount for SLL/SRL/SRA
//   result    combinational result
//   busy      mult/div engine running
//   stall     current op cannot be taken this cycle; hold inputs
//
// Mult/div run on magnitudes for 32 iterations (shift-add or restoring
// divide), then one FIXUP cycle applies signs and writes HI/LO.
module alu_multdiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [5:0]            fncode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            shamt,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  stall
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;

  logic [1:0]   state;
  logic [4:0]   cnt;
  logic [W-1:0] hi, lo;
  logic [W-1:0] w_hi, w_lo;     // working accumulator / remainder:quotient
  logic [W-1:0] opnd;           // multiplicand or divisor magnitude
  logic [W-1:0] a_lat;          // original dividend, for divide-by-zero
  logic         is_div, neg_res, neg_rem, div0;

  logic is_hilo, is_md, accept, md_signed;
  logic [W-1:0] a_mag, b_mag;

  assign busy    = (state != S_IDLE);
  assign is_hilo = (fncode == F_MFHI) || (fncode == F_MFLO) ||
                   (fncode == F_MTHI) || (fncode == F_MTLO);
  assign is_md   = (fncode == F_MULT) || (fncode == F_MULTU) ||
                   (fncode == F_DIV)  || (fncode == F_DIVU);
  assign stall   = op_valid & busy & (is_hilo | is_md);
  assign accept  = op_valid & ~busy & is_md;

  assign md_signed = (fncode == F_MULT) || (fncode == F_DIV);
  assign a_mag     = (md_signed && a[W-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (md_signed && b[W-1]) ? (~b + 1'b1) : b;

  // One iteration of each engine, evaluated from the working registers.
  logic [W:0]     mul_sum;
  logic [W:0]     div_trial;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] prod_neg;

  always_comb begin
    mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_trial = {w_hi, w_lo[W-1]};
    div_ge    = (div_trial >= {1'b0, opnd});
    // Only low bits matter: when div_ge the difference is below opnd.
    div_diff  = div_trial[W-1:0] - opnd;
    prod_neg  = ~{w_hi, w_lo} + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      opnd    <= '0;
      a_lat   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && fncode == F_MTHI) hi <= a;
          if (op_valid && fncode == F_MTLO) lo <= a;
          if (accept) begin
            is_div  <= fncode[1];
            neg_res <= md_signed & (a[W-1] ^ b[W-1]);
            neg_rem <= md_signed & a[W-1];
            div0    <= fncode[1] & (b == '0);
            a_lat   <= a;
            w_hi    <= '0;
            // mult: multiplier in w_lo, multiplicand in opnd
            // div : dividend in w_lo, divisor in opnd
            w_lo    <= fncode[1] ? a_mag : b_mag;
            opnd    <= fncode[1] ? b_mag : a_mag;
            cnt     <= 5'd31;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (is_div) begin
            w_hi <= div_ge ? div_diff : div_trial[W-1:0];
            w_lo <= {w_lo[W-2:0], div_ge};
          end else begin
            w_hi <= mul_sum[W:1];
            w_lo <= {mul_sum[0], w_lo[W-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (div0) begin
              hi <= a_lat;
              lo <= '1;
            end else begin
              lo <= neg_res ? (~w_lo + 1'b1) : w_lo;
              hi <= neg_rem ? (~w_hi + 1'b1) : w_hi;
            end
          end else begin
            {hi, lo} <= neg_res ? prod_neg : {w_hi, w_lo};
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic slt_s, slt_u;
  assign slt_s = ($signed(a) < $signed(b));
  assign slt_u = (a < b);

  always_comb begin
    result = '0;
    if (op_valid) begin
      case (fncode)
        F_SLL:  result = b << shamt;
        F_SRL:  result = b >> shamt;
        F_SRA:  result = $signed(b) >>> shamt;
        F_SLLV: result = b << a[4:0];
        F_SRLV: result = b >> a[4:0];
        F_SRAV: result = $signed(b) >>> a[4:0];
        F_ADDU: result = a + b;
        F_SUBU: result = a - b;
        F_AND:  result = a & b;
        F_OR:   result = a | b;
        F_XOR:  result = a ^ b;
        F_NOR:  result = ~(a | b);
        F_SLT:  result = {{(W-1){1'b0}}, slt_s};
        F_SLTU: result = {{(W-1){1'b0}}, slt_u};
        F_MFHI: result = busy ? '0 : hi;
        F_MFLO: result = busy ? '0 : lo;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multdiv.sv
// Directed bench for alu_multdiv: reset state, combinational ops, mult/div
// latency and results, interlock behaviour, HI/LO moves, mid-op reset.
module tb_alu_multdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  fncode;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy, stall;

  int tests = 0;
  int fails = 0;

  alu_multdiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .fncode(fncode),
    .a(a), .b(b), .shamt(shamt), .result(result), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sh);
    op_valid = 1'b1; fncode = f; a = av; b = bv; shamt = sh;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Issue a mult/div at the next edge, then count busy cycles (bounded).
  task automatic run_muldiv(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
    int n;
    set_in(f, av, bv, 5'd0);
    tick;
    set_in(6'b111111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd0);
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    tests++;
    if (busy !== 1'b0 || n != 33) begin
      fails++;
      $display("FAIL muldiv_latency: busy cycles %0d busy=%b, want 33 busy=0", n, busy);
    end
  endtask

  task automatic test_reset;
    op_valid = 1'b0; fncode = 6'b111111; a = '0; b = '0; shamt = '0;
    reset = 1'b0;
    #12;
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_flags: busy=%b stall=%b, want 0 0", busy, stall);
    end
    set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_mfhi: got %h stall=%b, want 0 0", result, stall);
    end
    set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0) begin
      fails++; $display("FAIL reset_mflo: got %h, want 0", result);
    end
    @(negedge clk);
    reset = 1'b1;
    tick;
  endtask

  task automatic test_comb;
    logic [5:0]  f_t[13]  = '{6'b000011, 6'b101010, 6'b101011, 6'b100011, 6'b111111,
                              6'b000000, 6'b000110, 6'b000111, 6'b100111, 6'b100110,
                              6'b101000, 6'b100001, 6'b100100};
    logic [31:0] a_t[13]  = '{32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h5,
                              32'h0, 32'h4, 32'h24, 32'h0, 32'h0000_F0F0,
                              32'h7, 32'hFFFF_FFFF, 32'hFF00_FF00};
    logic [31:0] b_t[13]  = '{32'h8000_0000, 32'h1, 32'h1, 32'h1, 32'h6,
                              32'h1, 32'h80, 32'hF000_0000, 32'h0, 32'h0000_FF00,
                              32'h9, 32'h2, 32'h0F0F_FFFF};
    logic [4:0]  s_t[13]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd9, 5'd0, 5'd0, 5'd0,
                              5'd0, 5'd0, 5'd0};
    logic [31:0] e_t[13]  = '{32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0,
                              32'h8000_0000, 32'h8, 32'hFF00_0000, 32'hFFFF_FFFF,
                              32'h0000_0FF0, 32'h0, 32'h1, 32'h0F00_FF00};
    for (int i = 0; i < 13; i++) begin
      set_in(f_t[i], a_t[i], b_t[i], s_t[i]); #1;
      tests++;
      if (result !== e_t[i] || stall !== 1'b0) begin
        fails++;
        $display("FAIL comb[%0d] fn=%b: got %h stall=%b, want %h stall=0",
                 i, f_t[i], result, stall, e_t[i]);
      end
    end
    op_valid = 1'b0; fncode = 6'b100001; a = 32'd3; b = 32'd4; #1;
    tests++;
    if (result !== 32'h0) begin
      fails++; $display("FAIL comb_invalid: got %h, want 0", result);
    end
    tick;
  endtask

  task automatic test_mult;
    int bad;
    set_in(6'b011000, 32'hFFFF_FFFD, 32'd5, 5'd0);
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL mult_issue_stall: got %b, want 0", stall);
    end
    tick;   // edge N
    set_in(6'b010010, 32'h0, 32'h0, 5'd0);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      if (stall !== 1'b1 || result !== 32'h0) bad++;
      tick;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL mult_stall_window: %0d of 33 cycles not stalled, want 0", bad);
    end
    tests++;
    if (stall !== 1'b0 || result !== 32'hFFFF_FFF1) begin
      fails++; $display("FAIL mult_lo: got %h stall=%b, want fffffff1 stall=0", result, stall);
    end
    set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL mult_hi: got %h, want ffffffff", result);
    end
    run_muldiv(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL multu_hi: got %h, want fffffffe", result);
    end
    set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0000_0001) begin
      fails++; $display("FAIL multu_lo: got %h, want 00000001", result);
    end
  endtask

  task automatic test_div;
    logic [5:0]  f_t[4] = '{6'b011010, 6'b011011, 6'b011010, 6'b011011};
    logic [31:0] a_t[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100};
    logic [31:0] b_t[4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] lo_t[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14};
    logic [31:0] hi_t[4] = '{32'hFFFF_FFFF, 32'd7, 32'h0, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_muldiv(f_t[i], a_t[i], b_t[i]);
      set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
      tests++;
      if (result !== lo_t[i]) begin
        fails++; $display("FAIL div_lo[%0d]: got %h, want %h", i, result, lo_t[i]);
      end
      set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
      tests++;
      if (result !== hi_t[i]) begin
        fails++; $display("FAIL div_hi[%0d]: got %h, want %h", i, result, hi_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    set_in(6'b011001, 32'd6, 32'd7, 5'd0);
    tick;
    set_in(6'b100001, 32'd3, 32'd4, 5'd0); #1;
    tests++;
    if (busy !== 1'b1 || result !== 32'd7 || stall !== 1'b0) begin
      fails++; $display("FAIL b2b_addu: got %h busy=%b stall=%b, want 7 1 0", result, busy, stall);
    end
    // Operand changes during the run must not leak into the result.
    set_in(6'b011001, 32'd3, 32'd3, 5'd0); #1;
    tests++;
    if (stall !== 1'b1 || result !== 32'h0) begin
      fails++; $display("FAIL b2b_stall: got stall=%b result=%h, want 1 0", stall, result);
    end
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (stall !== 1'b1) bad++;
      tick; n++;
    end
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0 || bad != 0) begin
      fails++; $display("FAIL b2b_release: busy=%b stall=%b unstalled=%0d, want 0 0 0", busy, stall, bad);
    end
    tick;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    set_in(6'b111111, 32'h0, 32'h0, 5'd0);
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (busy !== 1'b0 || result !== 32'd9) begin
      fails++; $display("FAIL b2b_second_lo: got %h busy=%b, want 9 0", result, busy);
    end
  endtask

  task automatic test_mthi_mtlo;
    set_in(6'b010001, 32'h0000_1234, 32'h0, 5'd0);
    tick;
    set_in(6'b010011, 32'h0000_ABCD, 32'h0, 5'd0);
    tick;
    set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0000_1234) begin
      fails++; $display("FAIL mthi: got %h, want 00001234", result);
    end
    set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0000_ABCD) begin
      fails++; $display("FAIL mtlo: got %h, want 0000abcd", result);
    end
  endtask

  task automatic test_reset_midop;
    set_in(6'b011011, 32'd100, 32'd3, 5'd0);
    tick;
    set_in(6'b111111, 32'h0, 32'h0, 5'd0);
    for (int k = 0; k < 10; k++) tick;
    reset = 1'b0; #1;
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL midop_reset_busy: busy=%b stall=%b, want 0 0", busy, stall);
    end
    @(negedge clk);
    reset = 1'b1;
    tick;
    set_in(6'b010010, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL midop_reset_lo: got %h busy=%b, want 0 0", result, busy);
    end
    set_in(6'b010000, 32'h0, 32'h0, 5'd0); #1;
    tests++;
    if (result !== 32'h0) begin
      fails++; $display("FAIL midop_reset_hi: got %h, want 0", result);
    end
  endtask

  initial begin
    test_reset;
    test_comb;
    test_mult;
    test_div;
    test_back_to_back;
    test_mthi_mtlo;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
